bd_rx_frame_buffer: RTL and testbench
=====================================

# bd_rx_frame_buffer

Receive-side frame buffer sitting directly downstream of the BD decoder stage. It accepts decoded bytes one per strobe, groups them into frames delimited by a last-byte marker, and stores only complete, valid frames in an internal FIFO. It presents them to the host over a valid/ready stream and raises `int_rx_host` while at least one complete frame is waiting. Frames that cannot fit, or that fail the optional checksum, are discarded whole, so the host never sees a partial frame.

## Interface
- `DEPTH`, 16: FIFO entries in bytes; power of two, ≥4.
- `G_CLK_RX`  in  1  receive clock; all logic is on the rising edge.
- `G_RST_RX_N`  in  1  asynchronous, active-low reset.
- `dec_data`  in  8  decoded byte from the decoder.
- `dec_valid`  in  1  one-cycle strobe; `dec_data`/`dec_last` are valid this cycle. No backpressure.
- `dec_last`  in  1  marks the final byte of the current frame.
- `m_data`  out  8  head byte; 0 when `m_valid`=0.
- `m_last`  out  1  head byte is the last byte of its frame; 0 when `m_valid`=0.
- `m_valid`  out  1  at least one committed byte is available.
- `m_ready`  in  1  host accepts the head byte when `m_valid`&`m_ready`.
- `frame_cnt`  out  $clog2(DEPTH)+1  number of complete frames held.
- `int_rx_host`  out  1  registered; high whenever `frame_cnt`≠0.
- `ovf_flag`  out  1  sticky; a frame was dropped for lack of space.
- `flag_clr`  in  1  clears the sticky flags for one cycle.

## Operation
- Storage: DEPTH×9 bits holding {last, data}. Pointers `wptr`, `wcommit`, and `rptr` are each $clog2(DEPTH)+1 bits wide and wrap naturally. Full is `wptr - rptr == DEPTH`.
- Write FSM states: IDLE, RECV, DROP.
  - IDLE, on `dec_valid`:
    - Store the byte at `wptr` and set `frame_start = wptr`.
    - If `dec_last`, commit. Otherwise go to RECV.
  - RECV, on `dec_valid`:
    - If not full, store the byte. If `dec_last`, commit and go to IDLE.
    - If full, rewind `wptr` to `frame_start` and set `ovf_flag`. If `dec_last`, go to IDLE; otherwise go to DROP.
  - DROP, on `dec_valid`: discard the byte. If `dec_last`, go to IDLE.
  - IDLE with full storage: the byte takes the RECV full path, so the frame is dropped and `ovf_flag` is set.
- Commit: `wcommit <= wptr+1` (the pointer after the last byte) and `frame_cnt` increments.
- Read side is first-word fall-through: `m_valid = (rptr != wcommit)`. Uncommitted bytes are never visible.
- Pop: on `m_valid & m_ready`, `rptr` increments. If `m_last` was set, `frame_cnt` decrements.
- Commit and last-byte pop in the same cycle leave `frame_cnt` unchanged.
- Frames longer than DEPTH bytes are always dropped.
- `flag_clr` clears the sticky flags. If a new drop occurs in the same cycle as `flag_clr`, the set wins.

## Timing
- Reset (async assert, release synchronous to `G_CLK_RX`):
  - Pointers = 0, FSM = IDLE, `frame_cnt` = 0.
  - `m_valid`, `m_data`, `m_last`, `int_rx_host`, `ovf_flag` (and `crc_err_flag`) = 0.
  - Any partial frame in progress is discarded.
- A frame whose last byte strobes at edge n gives `m_valid`=1 from cycle n+1 if the buffer was empty. `int_rx_host` rises at n+2 (registered from `frame_cnt`).
- Pop at edge n: the next byte appears, or `m_valid` falls, in cycle n+1. `int_rx_host` falls one cycle after `frame_cnt` reaches 0.
- Full throughput: one write and one read per cycle, concurrently.
- Space freed by a pop at edge n is usable by a write at edge n+1, not n.

## Configuration
- `BD_RX_CHECKSUM_EN` defined:
  - The last byte of each frame is an 8-bit checksum; the mod-256 sum of all frame bytes, including the checksum byte, must equal 0.
  - A failing frame is dropped at its last byte (`wptr` rewinds to `frame_start`, no commit) and sets sticky `crc_err_flag` (extra output, 1 bit, cleared by `flag_clr`).
  - The checksum byte is stored and delivered like any other byte.
- Not defined: no sum logic and no `crc_err_flag` port; every frame that fits is committed.

## Structure
- Shared package `bd_pkg`:
  - `bd_rx_state_e` (IDLE, RECV, DROP).
  - `BD_RX_DEPTH_DEF` = 16.
  - `bd_byte_t` (logic [7:0]).
- One sub-module, `bd_rx_fifo_mem`: DEPTH×9 register array with a registered write port and an asynchronous read port. Pointer, FSM and flag logic stay in the top.

## Test plan
- Reset, then the 3-byte frame 0x11, 0x22, 0x33 (last on 0x33) → `m_valid` at n+1, bytes popped in order, `m_last` only on 0x33, `frame_cnt` 1→0, `int_rx_host` high then low.
- `m_ready`=0, DEPTH=16, write a 10-byte frame then a 10-byte frame → first frame kept, second dropped, `ovf_flag`=1, `frame_cnt`=1. Then `flag_clr` → `ovf_flag`=0.
- Last byte of frame B committed in the same cycle as the last-byte pop of frame A → `frame_cnt` unchanged.
- 20-byte frame into an empty buffer with DEPTH=16 → dropped, no byte visible, `m_valid`=0 throughout.
- Reset asserted mid-frame after 4 bytes → all outputs 0. The next 2-byte frame is delivered intact.
- With `BD_RX_CHECKSUM_EN`: frame 0x10, 0x20, 0xD0 is committed; frame 0x10, 0x20, 0xD1 is dropped and sets `crc_err_flag`.

Source files
------------

// File: rtl/bd_pkg.sv
// Shared types and constants for the BD receive path.
// Imported by the frame buffer and its storage array.
package bd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DROP
   } bd_rx_state_e;

   localparam int BD_RX_DEPTH_DEF = 16;

   typedef logic [7:0] bd_byte_t;

endpackage

// File: rtl/bd_rx_fifo_mem.sv
// Frame buffer storage: DEPTH x {last, data}.
// Registered write port, asynchronous read port.
module bd_rx_fifo_mem
   import bd_pkg::*;
#(
   parameter int DEPTH = BD_RX_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [8:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [8:0]    rdata
);

   logic [8:0] mem [DEPTH];

   // write port; contents need no reset since reads are gated by valid
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bd_rx_frame_buffer.sv
// Receive frame buffer: only whole, valid frames reach the host.
// Optional checksum check enabled by BD_RX_CHECKSUM_EN.
module bd_rx_frame_buffer
   import bd_pkg::*;
#(
   parameter int DEPTH = BD_RX_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = AW + 1
) (
   input  logic          G_CLK_RX,
   input  logic          G_RST_RX_N,
   input  bd_byte_t      dec_data,
   input  logic          dec_valid,
   input  logic          dec_last,
   output bd_byte_t      m_data,
   output logic          m_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [PW-1:0] frame_cnt,
   output logic          int_rx_host,
   output logic          ovf_flag,
`ifdef BD_RX_CHECKSUM_EN
   output logic          crc_err_flag,
`endif
   input  logic          flag_clr
);

   bd_rx_state_e  state, state_n;
   logic [PW-1:0] wptr, wptr_n;
   logic [PW-1:0] wcommit, rptr;
   logic [PW-1:0] fstart, fstart_n;
   logic          full, pop, pop_last;
   logic          we, commit, ovf_set;
   logic [8:0]    head;
`ifdef BD_RX_CHECKSUM_EN
   bd_byte_t      sum_q, sum_n, sum_all;
   logic [PW-1:0] start;
   logic          crc_set;
`endif

   assign full     = (wptr - rptr) == PW'(DEPTH);
   assign m_valid  = rptr != wcommit;
   assign pop      = m_valid & m_ready;
   assign pop_last = pop & head[8];
   assign m_data   = m_valid ? head[7:0] : 8'h00;
   assign m_last   = m_valid & head[8];

   bd_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (G_CLK_RX),
      .we    (we),
      .waddr (wptr[AW-1:0]),
      .wdata ({dec_last, dec_data}),
      .raddr (rptr[AW-1:0]),
      .rdata (head)
   );

   // write FSM state and frame bookkeeping registers
   always_ff @(posedge G_CLK_RX or negedge G_RST_RX_N) begin
      if (!G_RST_RX_N) begin
         state  <= IDLE;
         wptr   <= '0;
         fstart <= '0;
`ifdef BD_RX_CHECKSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         state  <= state_n;
         wptr   <= wptr_n;
         fstart <= fstart_n;
`ifdef BD_RX_CHECKSUM_EN
         sum_q  <= sum_n;
`endif
      end
   end

   // next-state: store, commit or discard the incoming byte
   always_comb begin
      state_n  = state;
      wptr_n   = wptr;
      fstart_n = fstart;
      we       = 1'b0;
      commit   = 1'b0;
      ovf_set  = 1'b0;
`ifdef BD_RX_CHECKSUM_EN
      crc_set  = 1'b0;
      sum_n    = sum_q;
      sum_all  = (state == IDLE) ? dec_data : bd_byte_t'(sum_q + dec_data);
      start    = (state == IDLE) ? wptr : fstart;
`endif
      if (dec_valid) begin
         unique case (state)
            IDLE, RECV: begin
               if (full) begin
                  ovf_set = 1'b1;
                  wptr_n  = (state == IDLE) ? wptr : fstart;
                  state_n = dec_last ? IDLE : DROP;
               end else begin
                  we     = 1'b1;
                  wptr_n = wptr + PW'(1);
                  if (state == IDLE) fstart_n = wptr;
`ifdef BD_RX_CHECKSUM_EN
                  sum_n  = sum_all;
`endif
                  if (dec_last) begin
                     state_n = IDLE;
`ifdef BD_RX_CHECKSUM_EN
                     if (sum_all == 8'h00) begin
                        commit = 1'b1;
                     end else begin
                        crc_set = 1'b1;
                        wptr_n  = start;
                     end
`else
                     commit = 1'b1;
`endif
                  end else begin
                     state_n = RECV;
                  end
               end
            end
            DROP: begin
               if (dec_last) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // commit pointer, read pointer and frame count
   always_ff @(posedge G_CLK_RX or negedge G_RST_RX_N) begin
      if (!G_RST_RX_N) begin
         wcommit   <= '0;
         rptr      <= '0;
         frame_cnt <= '0;
      end else begin
         if (commit) wcommit <= wptr + PW'(1);
         if (pop) rptr <= rptr + PW'(1);
         if (commit && !pop_last) frame_cnt <= frame_cnt + PW'(1);
         else if (!commit && pop_last) frame_cnt <= frame_cnt - PW'(1);
      end
   end

   // host interrupt and sticky flags; a new set beats a clear
   always_ff @(posedge G_CLK_RX or negedge G_RST_RX_N) begin
      if (!G_RST_RX_N) begin
         int_rx_host  <= 1'b0;
         ovf_flag     <= 1'b0;
`ifdef BD_RX_CHECKSUM_EN
         crc_err_flag <= 1'b0;
`endif
      end else begin
         int_rx_host <= frame_cnt != '0;
         if (ovf_set) ovf_flag <= 1'b1;
         else if (flag_clr) ovf_flag <= 1'b0;
`ifdef BD_RX_CHECKSUM_EN
         if (crc_set) crc_err_flag <= 1'b1;
         else if (flag_clr) crc_err_flag <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_bd_rx_frame_buffer.sv
// Directed self-checking bench for bd_rx_frame_buffer.
// Checksum scenario runs only when BD_RX_CHECKSUM_EN is defined.
module tb_bd_rx_frame_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] dec_data;
   logic       dec_valid;
   logic       dec_last;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] frame_cnt;
   logic       int_rx_host;
   logic       ovf_flag;
   logic       flag_clr;
`ifdef BD_RX_CHECKSUM_EN
   logic       crc_err_flag;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bd_rx_frame_buffer #(.DEPTH(16)) dut (
      .G_CLK_RX    (clk),
      .G_RST_RX_N  (rst_n),
      .dec_data    (dec_data),
      .dec_valid   (dec_valid),
      .dec_last    (dec_last),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .frame_cnt   (frame_cnt),
      .int_rx_host (int_rx_host),
      .ovf_flag    (ovf_flag),
`ifdef BD_RX_CHECKSUM_EN
      .crc_err_flag(crc_err_flag),
`endif
      .flag_clr    (flag_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      dec_data  = d;
      dec_last  = l;
      dec_valid = 1'b1;
      tick();
      dec_valid = 1'b0;
      dec_last  = 1'b0;
      dec_data  = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_m_valid got %b want 0", m_valid);
      end
      n_cmp++;
      if (m_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_m_data got %h want 00", m_data);
      end
      n_cmp++;
      if (m_last !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_m_last got %b want 0", m_last);
      end
      n_cmp++;
      if (frame_cnt !== 5'd0) begin
         n_bad++;
         $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
      end
      n_cmp++;
      if (int_rx_host !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_int got %b want 0", int_rx_host);
      end
      n_cmp++;
      if (ovf_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ovf got %b want 0", ovf_flag);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h11;
      exp_d[1] = 8'h22;
      exp_d[2] = 8'h33;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_partial_hidden got %b want 0", m_valid);
      end
      send(8'h33, 1'b1);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'h11) begin
         n_bad++;
         $display("FAIL basic_first got v=%b d=%h want v=1 d=11", m_valid, m_data);
      end
      n_cmp++;
      if (frame_cnt !== 5'd1 || int_rx_host !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_cnt_n1 got cnt=%0d int=%b want 1/0", frame_cnt, int_rx_host);
      end
      tick();
      n_cmp++;
      if (int_rx_host !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_int_rise got %b want 1", int_rx_host);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 2)) begin
            n_bad++;
            $display("FAIL basic_pop%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, m_valid, m_data, m_last, exp_d[i], (i == 2));
         end
         tick();
      end
      m_ready = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b0 || frame_cnt !== 5'd0 || int_rx_host !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_drained got v=%b cnt=%0d int=%b want 0/0/1",
                  m_valid, frame_cnt, int_rx_host);
      end
      tick();
      n_cmp++;
      if (int_rx_host !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_int_fall got %b want 0", int_rx_host);
      end
   endtask

   task automatic test_overflow();
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), i == 9);
      for (int i = 0; i < 10; i++) send(8'hB0 + 8'(i), i == 9);
      n_cmp++;
      if (frame_cnt !== 5'd1 || ovf_flag !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_drop got cnt=%0d ovf=%b want 1/1", frame_cnt, ovf_flag);
      end
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      n_cmp++;
      if (ovf_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear got %b want 0", ovf_flag);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (m_valid !== 1'b1 || m_data !== 8'hA0 + 8'(i) || m_last !== (i == 9)) begin
            n_bad++;
            $display("FAIL ovf_pop%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, m_valid, m_data, m_last, 8'hA0 + 8'(i), (i == 9));
         end
         tick();
      end
      m_ready = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b0 || frame_cnt !== 5'd0) begin
         n_bad++;
         $display("FAIL ovf_second_hidden got v=%b cnt=%0d want 0/0", m_valid, frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b0;
      send(8'h01, 1'b0);
      send(8'h02, 1'b1);
      send(8'h03, 1'b0);
      m_ready = 1'b1;
      tick();
      n_cmp++;
      if (frame_cnt !== 5'd1 || m_data !== 8'h02 || m_last !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_pre got cnt=%0d d=%h l=%b want 1/02/1", frame_cnt, m_data, m_last);
      end
      send(8'h04, 1'b1);
      m_ready = 1'b0;
      n_cmp++;
      if (frame_cnt !== 5'd1 || m_valid !== 1'b1 || m_data !== 8'h03) begin
         n_bad++;
         $display("FAIL b2b_same_cycle got cnt=%0d v=%b d=%h want 1/1/03",
                  frame_cnt, m_valid, m_data);
      end
      m_ready = 1'b1;
      tick();
      n_cmp++;
      if (m_data !== 8'h04 || m_last !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_tail got d=%h l=%b want 04/1", m_data, m_last);
      end
      tick();
      m_ready = 1'b0;
      n_cmp++;
      if (frame_cnt !== 5'd0 || m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_drained got cnt=%0d v=%b want 0/0", frame_cnt, m_valid);
      end
   endtask

   task automatic test_long_frame();
      int vis;
      vis = 0;
      for (int i = 0; i < 20; i++) begin
         send(8'(i), i == 19);
         if (m_valid !== 1'b0) vis++;
      end
      n_cmp++;
      if (vis !== 0) begin
         n_bad++;
         $display("FAIL long_visible got %0d cycles with m_valid want 0", vis);
      end
      n_cmp++;
      if (ovf_flag !== 1'b1 || frame_cnt !== 5'd0) begin
         n_bad++;
         $display("FAIL long_drop got ovf=%b cnt=%0d want 1/0", ovf_flag, frame_cnt);
      end
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      send(8'h77, 1'b1);
      for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 ||
          frame_cnt !== 5'd0 || int_rx_host !== 1'b0 || ovf_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_outputs got v=%b d=%h l=%b cnt=%0d int=%b ovf=%b want all 0",
                  m_valid, m_data, m_last, frame_cnt, int_rx_host, ovf_flag);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send(8'h5A, 1'b0);
      send(8'hA5, 1'b1);
      m_ready = 1'b1;
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'h5A || m_last !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_b0 got v=%b d=%h l=%b want 1/5A/0", m_valid, m_data, m_last);
      end
      tick();
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_last !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_b1 got v=%b d=%h l=%b want 1/A5/1", m_valid, m_data, m_last);
      end
      tick();
      m_ready = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b0 || frame_cnt !== 5'd0) begin
         n_bad++;
         $display("FAIL midrst_drained got v=%b cnt=%0d want 0/0", m_valid, frame_cnt);
      end
   endtask

`ifdef BD_RX_CHECKSUM_EN
   task automatic test_checksum();
      send(8'h10, 1'b0);
      send(8'h20, 1'b0);
      send(8'hD0, 1'b1);
      n_cmp++;
      if (frame_cnt !== 5'd1 || crc_err_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL crc_good got cnt=%0d err=%b want 1/0", frame_cnt, crc_err_flag);
      end
      send(8'h10, 1'b0);
      send(8'h20, 1'b0);
      send(8'hD1, 1'b1);
      n_cmp++;
      if (frame_cnt !== 5'd1 || crc_err_flag !== 1'b1) begin
         n_bad++;
         $display("FAIL crc_bad got cnt=%0d err=%b want 1/1", frame_cnt, crc_err_flag);
      end
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      dec_data  = 8'h00;
      dec_valid = 1'b0;
      dec_last  = 1'b0;
      m_ready   = 1'b0;
      flag_clr  = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_long_frame();
      test_reset_mid_frame();
`ifdef BD_RX_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
